pc_predict_unit: RTL
====================

Name: pc_predict_unit

Overview:
Parametrised next-PC generator with a dynamic branch predictor for the five-stage pipeline. It supersedes the single-record static selector.
- IF stage: predicts next PC using a BHT of 2-bit saturating counters, plus static JAL handling.
- Record queue: keeps one prediction record per in-flight instruction, RESOLVE_DEPTH deep.
- EX stage: compares resolved outcome against the oldest record, raises flush on mismatch, redirects PC and trains the BHT.

Parameters:
XLEN, 32, PC/immediate width
BHT_IDX_W, 6, log2 of BHT entries (64); index = pc[BHT_IDX_W+1:2]
RESOLVE_DEPTH, 2, instructions between IF prediction and EX resolution (min 1)
RESET_PC, 32'h0000_0000, pc_next value while rst is high

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
stall  in  1  IF/ID stall; holds PC and record queue
if_pc  in  XLEN  PC of instruction in IF
if_opcode  in  7  opcode of IF instruction
if_j_imm  in  XLEN  sign-extended JAL offset
if_b_imm  in  XLEN  sign-extended conditional-branch offset
ex_valid  in  1  EX holds a real (non-bubble) instruction
ex_is_branch  in  1  EX instruction is conditional branch (trains BHT)
ex_taken  in  1  resolved taken (branch taken, or JAL/JALR)
ex_pc  in  XLEN  PC of EX instruction
ex_target  in  XLEN  resolved target
pc_next  out  XLEN  PC to load next cycle
pred_taken  out  1  IF prediction (debug/trace)
flush  out  1  mispredict; squash IF/ID and ID/EX

Behaviour:
- Prediction (combinational, 0-cycle):
  - JAL: taken, target if_pc+if_j_imm.
  - Conditional BRANCH: taken iff BHT[idx][1]==1, target if_pc+if_b_imm.
  - All other opcodes, including JALR: not taken, target if_pc+4.
  - All sums are modulo 2^XLEN.
- Record queue: RESOLVE_DEPTH entries of {valid, taken, target}. Entry 0 is the oldest.
  - rst: all valid=0.
  - flush: all valid=0 at the next edge. Flush overrides stall.
  - stall (no flush): hold.
  - Otherwise: shift toward entry 0 and load the new IF prediction into entry RESOLVE_DEPTH-1 with valid=1.
- Mispredict (combinational, same cycle as ex_valid):
  - flush = ex_valid & ~rst & (h_taken != ex_taken | (ex_taken & h_target != ex_target)).
  - h_taken and h_target come from entry 0. If entry 0 is invalid, use h_taken=0.
- pc_next priority:
  1. rst: RESET_PC.
  2. flush: ex_taken ? ex_target : ex_pc+4.
  3. stall: if_pc.
  4. otherwise: predicted target.
- BHT:
  - 2^BHT_IDX_W counters, reset to 2'b01 (weakly not-taken); all entries clear in one reset cycle.
  - On edge with ex_valid & ex_is_branch & ~rst: increment if ex_taken, else decrement, at index ex_pc[BHT_IDX_W+1:2]. Saturate at 2'b11 and 2'b00.
  - Update happens regardless of stall/flush.
  - Same-cycle read/write to the same index: IF reads the old value (no bypass).
- Reset values: flush=0, pred_taken=0, pc_next=RESET_PC while rst is high.
- Reset mid-operation: queue and BHT cleared; no flush asserted during or in the cycle after rst.

Optional Feature:
PRED_STATS_EN
- Defined: adds outputs stat_branches [31:0] and stat_mispred [31:0].
  - stat_branches increments on each ex_valid & ex_is_branch.
  - stat_mispred increments on each flush.
  - Both wrap at 2^32 and clear on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset: rst=1 for 2 cycles -> pc_next=0x0, flush=0. After release, a BRANCH at 0x40 predicts not-taken (BHT=01) -> pc_next=0x44.
2. JAL at if_pc=0x100, if_j_imm=0x20 -> pred_taken=1, pc_next=0x120. RESOLVE_DEPTH cycles later, EX ex_taken=1, ex_target=0x120 -> flush=0.
3. Branch at 0x40 resolved taken twice (ex_target=0x80) -> BHT goes 01->10->11. Next IF at 0x40 with if_b_imm=0x40 -> pred_taken=1, pc_next=0x80. Four not-taken resolutions -> counter saturates at 00, not below.
4. Mispredict: head record not-taken; EX ex_taken=1, ex_pc=0x200, ex_target=0x300 -> flush=1 same cycle, pc_next=0x300, all records invalid next cycle. Reverse case (head taken, resolved not-taken) -> pc_next=0x204.
5. Stall: stall=1 for 3 cycles with if_pc=0x50 -> pc_next=0x50 and queue unchanged. Flush during stall -> flush wins, pc_next=redirect, queue cleared.
6. PRED_STATS_EN: 5 branches with 2 mispredicts -> stat_branches=5, stat_mispred=2. Assert rst -> both 0.

Source files
------------

// File: rtl/pc_predict_unit.sv
// Next-PC generator: 2-bit saturating BHT prediction, in-flight record queue and EX-stage mispredict recovery.
// Define PRED_STATS_EN to add the stat_branches / stat_mispred counters.
module pc_predict_unit #(
    parameter int unsigned     XLEN          = 32,
    parameter int unsigned     BHT_IDX_W     = 6,
    parameter int unsigned     RESOLVE_DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC      = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [XLEN-1:0] if_pc,
    input  logic [6:0]      if_opcode,
    input  logic [XLEN-1:0] if_j_imm,
    input  logic [XLEN-1:0] if_b_imm,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    output logic [XLEN-1:0] pc_next,
    output logic            pred_taken,
    output logic            flush
`ifdef PRED_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
`endif
);

    localparam logic [6:0]      OPC_JAL    = 7'b1101111;
    localparam logic [6:0]      OPC_BRANCH = 7'b1100011;
    localparam int unsigned     BHT_SIZE   = 1 << BHT_IDX_W;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    logic [1:0]           bht [BHT_SIZE];
    logic [BHT_IDX_W-1:0] if_idx;
    logic [BHT_IDX_W-1:0] ex_idx;

    logic                 q_valid  [RESOLVE_DEPTH];
    logic                 q_taken  [RESOLVE_DEPTH];
    logic [XLEN-1:0]      q_target [RESOLVE_DEPTH];

    logic                 pred_taken_c;
    logic [XLEN-1:0]      pred_next;
    logic                 h_taken;
    logic                 mispredict;
    logic                 rst_d;

    assign if_idx = if_pc[BHT_IDX_W+1:2];
    assign ex_idx = ex_pc[BHT_IDX_W+1:2];

    // IF prediction; the recorded target is the PC actually fetched next
    always_comb begin
        pred_taken_c = 1'b0;
        pred_next    = if_pc + PC_STEP;
        case (if_opcode)
            OPC_JAL: begin
                pred_taken_c = 1'b1;
                pred_next    = if_pc + if_j_imm;
            end
            OPC_BRANCH: begin
                if (bht[if_idx][1]) begin
                    pred_taken_c = 1'b1;
                    pred_next    = if_pc + if_b_imm;
                end
            end
            default: ;
        endcase
    end

    assign h_taken    = q_valid[0] & q_taken[0];
    assign mispredict = (h_taken != ex_taken) | (ex_taken & (q_target[0] != ex_target));

    // rst_d masks the cycle after reset, when the queue holds no records yet
    assign flush      = ex_valid & ~rst & ~rst_d & mispredict;
    assign pred_taken = ~rst & pred_taken_c;

    always_comb begin
        if (rst)
            pc_next = RESET_PC;
        else if (flush)
            pc_next = ex_taken ? ex_target : ex_pc + PC_STEP;
        else if (stall)
            pc_next = if_pc;
        else
            pc_next = pred_next;
    end

    always_ff @(posedge clk) begin
        rst_d <= rst;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int unsigned i = 0; i < RESOLVE_DEPTH; i++)
                q_valid[i] <= 1'b0;
        end else if (!stall) begin
            for (int unsigned i = 0; i + 1 < RESOLVE_DEPTH; i++) begin
                q_valid[i]  <= q_valid[i+1];
                q_taken[i]  <= q_taken[i+1];
                q_target[i] <= q_target[i+1];
            end
            q_valid[RESOLVE_DEPTH-1]  <= 1'b1;
            q_taken[RESOLVE_DEPTH-1]  <= pred_taken_c;
            q_target[RESOLVE_DEPTH-1] <= pred_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_SIZE; i++)
                bht[i] <= 2'b01;
        end else if (ex_valid && ex_is_branch) begin
            if (ex_taken) begin
                if (bht[ex_idx] != 2'b11)
                    bht[ex_idx] <= bht[ex_idx] + 2'b01;
            end else begin
                if (bht[ex_idx] != 2'b00)
                    bht[ex_idx] <= bht[ex_idx] - 2'b01;
            end
        end
    end

`ifdef PRED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (ex_valid && ex_is_branch)
                stat_branches <= stat_branches + 32'd1;
            if (flush)
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule
